ifid_skid_reg: RTL
==================

// Module: ifid_skid_reg
// PURPOSE
//   Two-entry skid-buffered pipeline register between instruction fetch and decode.
//   Built from the team's flop primitive style, with a full valid/ready handshake on both sides.
//   Registers the fetched {pc, instr} pair and sustains 1 beat/cycle under decode back-pressure.
//   Supports a synchronous flush (branch/jump redirect) that discards all in-flight entries.
// PARAMETERS
//   PC_W       32             width of program-counter field
//   INSTR_W    32             width of instruction field
//   NOP_INSTR  32'h0000_0000  value driven on out_instr whenever out_valid=0
// PORTS
//   clock      in   1        rising-edge clock, sole clock domain
//   reset      in   1        synchronous, active-low reset (asserted when 0, sampled on clock edge)
//   flush      in   1        synchronous flush; discards both entries
//   in_valid   in   1        upstream beat valid
//   in_ready   out  1        stage can accept a beat (registered)
//   in_pc      in   PC_W     upstream PC
//   in_instr   in   INSTR_W  upstream instruction
//   out_valid  out  1        downstream beat valid
//   out_ready  in   1        downstream can accept
//   out_pc     out  PC_W     PC of head entry
//   out_instr  out  INSTR_W  instruction of head entry
//   occupancy  out  2        number of held entries (0..2)
// BEHAVIOUR
//   - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready; evaluated per clock edge.
//   - Storage: main reg (head, drives outputs) + skid reg; states EMPTY/ONE/TWO = occupancy 0/1/2.
//   - Reset (reset=0 at edge): state EMPTY, out_valid=0, out_pc=0, out_instr=NOP_INSTR,
//     in_ready=1, occupancy=0; a beat offered in a reset cycle is dropped.
//   - Priority per edge: reset > flush > normal transfer.
//   - EMPTY: in_fire -> ONE, main<=in.
//   - ONE: in_fire&out_fire -> ONE, main<=in; in_fire&!out_fire -> TWO, skid<=in;
//     !in_fire&out_fire -> EMPTY; neither -> hold.
//   - TWO: in_ready=0 so no in_fire; out_fire -> ONE, main<=skid; else hold.
//   - in_ready registered: next value = (next state != TWO); no comb path in_*/out_ready->in_ready.
//   - Latency: beat accepted at edge N is on outputs after edge N when EMPTY. Throughput 1/cycle
//     with out_ready=1. Order strictly FIFO, no duplication/loss except by flush/reset.
//   - While out_valid=1 & out_ready=0, out_pc/out_instr stay stable until out_fire.
//   - out_valid=0 => out_pc=0, out_instr=NOP_INSTR (decode sees a bubble).
//   - Flush at edge: next state EMPTY, in_ready=1; a beat handshaken in that same cycle is
//     discarded; a concurrent out_fire still counts as consumed downstream.
//   - occupancy always equals state encoding; never exceeds 2.
// TESTING
//   1 reset=0 two cycles, in_valid=1 -> out_valid=0, out_instr=0, in_ready=1, occupancy=0.
//   2 out_ready=1, stream pc 0x0,0x4,0x8 back-to-back -> out_pc 0x0,0x4,0x8 on consecutive
//     cycles, one cycle after each accept, occupancy=1 steady.
//   3 out_ready=0, send pc 0x10,0x14 -> occupancy=2, in_ready=0, out_pc holds 0x10;
//     raise out_ready -> 0x10 then 0x14 delivered, in_ready=1 after first out_fire.
//   4 occupancy=2, flush=1 with in_valid=1 pc 0x20 -> next cycle out_valid=0, occupancy=0,
//     0x20 never appears at output.
//   5 reset=0 asserted mid-stream at occupancy=2 -> next cycle all outputs at reset values.
//   6 random in_valid/out_ready 10k cycles vs scoreboard -> order preserved, no loss/dup,
//     outputs stable under stall.

Source files
------------

// File: rtl/ifid_skid_reg.sv
// rtl/ifid_skid_reg.sv - two-entry skid-buffered IF/ID pipeline register with flush
module ifid_skid_reg #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  // State encoding equals the number of held entries, so occupancy is the state itself.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [PC_W-1:0]    main_pc;
  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic               in_fire;
  logic               out_fire;
  logic               load_main_in;
  logic               load_main_skid;
  logic               load_skid;

  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign occupancy = state;

  // Head entry drives decode; an empty stage presents a bubble instead of stale data.
  assign out_pc    = out_valid ? main_pc : '0;
  assign out_instr = out_valid ? main_instr : NOP_INSTR;

  // Next-state and register-load selection; flush overrides any transfer this edge.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // State, registered in_ready (no combinational path from either handshake) and data flops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      main_pc    <= '0;
      main_instr <= NOP_INSTR;
      skid_pc    <= '0;
      skid_instr <= NOP_INSTR;
    end else begin
      state    <= state_next;
      in_ready <= (state_next != TWO);
      if (load_main_in) begin
        main_pc    <= in_pc;
        main_instr <= in_instr;
      end else if (load_main_skid) begin
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
      end
      if (load_skid) begin
        skid_pc    <= in_pc;
        skid_instr <= in_instr;
      end
    end
  end

endmodule
